// File: rtl/mem_queue_pkg.sv
// Shared types and sizing for the memory request queue.
// Request word layout is {op, tag, addr}; op encodings used by push decode.
package mem_queue_pkg;
    localparam int REQUEST_SIZE   = 38;
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 128;
    localparam int QUEUE_SIZE     = 16;
    localparam int QUEUE_SIZE_BIT = 4;
    localparam int COUNTER_WIDTH  = 10;
    localparam int CYCLE_NUM_DATA = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1
    } op_e;

    typedef struct packed {
        logic [1:0]            op;
        logic [3:0]            tag;
        logic [ADDR_WIDTH-1:0] addr;
    } req_t;
endpackage

// File: rtl/mem_queue_search.sv
// Priority address matcher: youngest valid entry (furthest from head) wins.
// Purely combinational; outputs are zero when disabled or on a miss.
module mem_queue_search
    import mem_queue_pkg::*;
(
    input  logic                                  i_en,
    input  logic [ADDR_WIDTH-1:0]                 i_addr,
    input  logic [QUEUE_SIZE-1:0]                 i_valid,
    input  logic [QUEUE_SIZE-1:0][ADDR_WIDTH-1:0] i_entry_addr,
    input  logic [QUEUE_SIZE_BIT-1:0]             i_head,
    output logic                                  o_match,
    output logic [QUEUE_SIZE_BIT-1:0]             o_index
);
    logic [QUEUE_SIZE_BIT-1:0] w_idx;

    // Walk oldest to youngest so the last hit seen is the youngest.
    always_comb begin
        o_match = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = 0; k < QUEUE_SIZE; k++) begin
            w_idx = i_head + QUEUE_SIZE_BIT'(k);
            if (i_en && i_valid[w_idx] && (i_entry_addr[w_idx] == i_addr)) begin
                o_match = 1'b1;
                o_index = w_idx;
            end
        end
    end
endmodule

// File: rtl/mem_queue_blk.sv
// 16-entry memory request FIFO with per-entry data line, address search and line fetch.
// Pop result is registered (1 cycle); pushes drop when full (unless popping) or while write data is pending.
module mem_queue_blk
    import mem_queue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                op,
    input  logic                      push_en,
    input  logic                      pop_en,
    input  logic                      search_en,
    input  logic                      fetch_en,
    input  logic [REQUEST_SIZE-1:0]   buf_in,
    input  logic [ADDR_WIDTH-1:0]     search_addr,
    input  logic [QUEUE_SIZE_BIT-1:0] fetch_index,
    output logic [REQUEST_SIZE-1:0]   buf_out,
    output logic                      valid_output,
    output logic                      search_match,
    output logic [QUEUE_SIZE_BIT-1:0] search_match_index,
    output logic                      search_match_receiving,
    output logic [DATA_WIDTH-1:0]     fetch_data,
    output logic                      empty,
    output logic                      full
);
    localparam int BEAT_BITS = $clog2(CYCLE_NUM_DATA);

    req_t                      r_entry [QUEUE_SIZE];
    logic [COUNTER_WIDTH-1:0]  r_age   [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]     r_valid;
    logic [QUEUE_SIZE-1:0]     r_recv;
    logic [QUEUE_SIZE_BIT-1:0] r_head;
    logic [QUEUE_SIZE_BIT-1:0] r_tail;
    logic [QUEUE_SIZE_BIT-1:0] r_rx_idx;
    logic [QUEUE_SIZE_BIT:0]   r_count;
    logic [BEAT_BITS-1:0]      r_beat;
    logic [DATA_WIDTH-1:0]     data_table [0:QUEUE_SIZE-1];

    logic                      w_rx_busy;
    logic                      w_pop;
    logic                      w_push_ok;
    logic                      w_push;
    logic                      w_push_wr;
    logic                      w_data_beat;
    logic [QUEUE_SIZE_BIT:0]   w_count_nxt;
    logic [QUEUE_SIZE-1:0][ADDR_WIDTH-1:0] w_entry_addr;
    logic                      w_unused_op_bits;

    // op travels on its own port, so the op bits of the bus word are ignored.
    assign w_unused_op_bits = ^buf_in[REQUEST_SIZE-1:REQUEST_SIZE-2];

    assign w_rx_busy   = |r_recv;
    assign w_pop       = pop_en && !empty && !r_recv[r_head];
    // A pop frees the head slot this cycle, so a full queue can still accept a push.
    assign w_push_ok   = push_en && !w_rx_busy && (!full || w_pop);
    assign w_push_wr   = w_push_ok && (op == OP_WRITE);
    assign w_push      = w_push_ok && ((op == OP_READ) || (op == OP_WRITE));
    assign w_data_beat = push_en && w_rx_busy;
    assign w_count_nxt = r_count + {{QUEUE_SIZE_BIT{1'b0}}, w_push}
                                 - {{QUEUE_SIZE_BIT{1'b0}}, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_rx_idx     <= '0;
            r_count      <= '0;
            r_beat       <= '0;
            r_valid      <= '0;
            r_recv       <= '0;
            buf_out      <= '0;
            valid_output <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                r_entry[i] <= '0;
                r_age[i]   <= '0;
            end
        end else begin
            valid_output <= w_pop;
            if (w_pop) begin
                buf_out         <= r_entry[r_head];
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // Push follows pop so a push into the just-freed head slot keeps its valid bit.
            if (w_push) begin
                r_entry[r_tail] <= {op, buf_in[REQUEST_SIZE-3:0]};
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
                if (w_push_wr) begin
                    r_recv[r_tail] <= 1'b1;
                    r_rx_idx       <= r_tail;
                    r_beat         <= '0;
                end
            end
            if (w_data_beat) begin
                r_beat <= r_beat + 1'b1;
                if (r_beat == BEAT_BITS'(CYCLE_NUM_DATA - 1))
                    r_recv[r_rx_idx] <= 1'b0;
            end
            r_count <= w_count_nxt;
            empty   <= (w_count_nxt == '0);
            full    <= (w_count_nxt == (QUEUE_SIZE_BIT+1)'(QUEUE_SIZE));
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (w_push && (r_tail == QUEUE_SIZE_BIT'(i)))
                    r_age[i] <= '0;
                else if (r_valid[i] && (r_age[i] != '1))
                    r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end

    // Lines are left unreset so a preloaded image survives reset.
    always_ff @(posedge clk) begin
        if (w_data_beat)
            data_table[r_rx_idx][{r_beat, 5'b0} +: 32] <= buf_in[31:0];
    end

    assign fetch_data = fetch_en ? data_table[fetch_index] : '0;

    always_comb begin
        w_entry_addr = '0;
        for (int i = 0; i < QUEUE_SIZE; i++)
            w_entry_addr[i] = r_entry[i].addr;
    end

    mem_queue_search u_search (
        .i_en         (search_en),
        .i_addr       (search_addr),
        .i_valid      (r_valid),
        .i_entry_addr (w_entry_addr),
        .i_head       (r_head),
        .o_match      (search_match),
        .o_index      (search_match_index)
    );

    assign search_match_receiving = search_match && r_recv[search_match_index];
endmodule

// File: tb/tb_mem_queue_blk.sv
// Randomized bench for mem_queue_blk: queue-level reference model, pop scoreboard,
// plus directed checks of the documented request/data examples.
module tb_mem_queue_blk;
    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   op;
    logic         push_en, pop_en, search_en, fetch_en;
    logic [37:0]  buf_in;
    logic [31:0]  search_addr;
    logic [3:0]   fetch_index;
    logic [37:0]  buf_out;
    logic         valid_output, search_match, search_match_receiving, empty, full;
    logic [3:0]   search_match_index;
    logic [127:0] fetch_data;

    always #5 clk = ~clk;

    mem_queue_blk dut (
        .clk(clk), .rst(rst), .op(op), .push_en(push_en), .pop_en(pop_en),
        .search_en(search_en), .fetch_en(fetch_en), .buf_in(buf_in),
        .search_addr(search_addr), .fetch_index(fetch_index), .buf_out(buf_out),
        .valid_output(valid_output), .search_match(search_match),
        .search_match_index(search_match_index),
        .search_match_receiving(search_match_receiving),
        .fetch_data(fetch_data), .empty(empty), .full(full)
    );

    typedef struct { logic [37:0] req; int slot; } ment_t;
    ment_t        mq[$];
    logic [37:0]  exp_q[$];
    logic [127:0] dt [16];
    int           m_tail = 0;
    bit           rx_active = 0;
    int           rx_slot = 0;
    int           rx_beat = 0;
    int           n_vec = 0;
    int           n_bad = 0;
    logic [37:0]  mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: apply inputs, check comb/registered outputs, advance model.
    task automatic cycle(input logic pe, input logic [1:0] o, input logic [37:0] bi,
                         input logic po, input logic se, input logic [31:0] sa,
                         input logic fe, input logic [3:0] fi);
        bit hit, rcv, do_pop, do_push;
        int idx;
        push_en = pe; op = o; buf_in = bi; pop_en = po;
        search_en = se; search_addr = sa; fetch_en = fe; fetch_index = fi;
        #1;
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == 16);
        hit = 0; rcv = 0; idx = 0;
        if (se)
            for (int k = mq.size() - 1; k >= 0; k--)
                if (!hit && mq[k].req[31:0] == sa) begin
                    hit = 1;
                    idx = mq[k].slot;
                    rcv = rx_active && (rx_slot == idx);
                end
        chk("search_match", search_match, hit);
        chk("search_index", search_match_index, idx[3:0]);
        chk("search_rcv", search_match_receiving, rcv);
        chk("fetch_data", fetch_data, fe ? dt[fi] : 128'h0);

        do_pop  = po && mq.size() > 0 && !(rx_active && mq[0].slot == rx_slot);
        do_push = 0;
        if (rx_active) begin
            if (pe) begin
                dt[rx_slot][32*rx_beat +: 32] = bi[31:0];
                rx_beat++;
                if (rx_beat == 4) rx_active = 0;
            end
        end else if (pe && o < 2 && (mq.size() < 16 || do_pop)) begin
            do_push = 1;
        end
        if (do_pop) begin
            exp_q.push_back(mq[0].req);
            void'(mq.pop_front());
        end
        if (do_push) begin
            mq.push_back('{req: {o, bi[35:0]}, slot: m_tail});
            if (o == 2'd1) begin
                rx_active = 1; rx_slot = m_tail; rx_beat = 0;
            end
            m_tail = (m_tail + 1) % 16;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic po, input logic se, input logic [31:0] sa,
                        input logic fe, input logic [3:0] fi);
        cycle(1'b0, 2'd0, 38'h0, po, se, sa, fe, fi);
    endtask

    // Scoreboard monitor: every valid_output pulse must match the oldest expected pop.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && valid_output === 1'b1) begin
                if (exp_q.size() == 0) chk("pop_unexpected", valid_output, 1'b0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("buf_out", buf_out, mon_e);
                end
            end
        end
    end

    initial begin
        logic [37:0] bi;
        logic [1:0]  o;
        int          r;
        rst = 1'b1; op = 2'd0; push_en = 0; pop_en = 0; search_en = 0; fetch_en = 0;
        buf_in = '0; search_addr = '0; fetch_index = '0;
        for (int i = 0; i < 16; i++) begin
            dt[i] = {$urandom, $urandom, $urandom, $urandom};
            dut.data_table[i] <= dt[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_valid_output", valid_output, 1'b0);
        chk("rst_buf_out", buf_out, 38'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: one read, one write with four data beats.
        cycle(1, 2'd0, 38'h00_2222_0000, 0, 0, 0, 0, 0);
        cycle(1, 2'd1, 38'h00_0000_0001, 0, 0, 0, 0, 0);
        cycle(1, 2'd0, 38'h00_1122_3344, 0, 1, 32'h1, 0, 0);
        search_en = 1; search_addr = 32'h1; #1;
        chk("dir_rx_match", search_match, 1'b1);
        chk("dir_rx_index", search_match_index, 4'd1);
        chk("dir_rx_receiving", search_match_receiving, 1'b1);
        cycle(1, 2'd0, 38'h00_5566_7788, 0, 1, 32'h1, 0, 0);
        cycle(1, 2'd0, 38'h00_9900_AABB, 0, 1, 32'h1, 0, 0);
        cycle(1, 2'd0, 38'h00_CCDD_EEFF, 0, 1, 32'h1, 0, 0);
        push_en = 0; search_en = 1; search_addr = 32'h1; fetch_en = 1; fetch_index = 4'd1; #1;
        chk("dir_done_receiving", search_match_receiving, 1'b0);
        chk("dir_done_match", search_match, 1'b1);
        chk("dir_line1", fetch_data, 128'hCCDDEEFF_9900AABB_55667788_11223344);
        chk("dir_count2", mq.size() == 2 && !empty, 1'b1);
        idle(1, 0, 0, 0, 0);
        chk("dir_pop1_data", buf_out, 38'h00_2222_0000);
        chk("dir_pop1_valid", valid_output, 1'b1);
        idle(1, 0, 0, 0, 0);
        chk("dir_pop2_data", buf_out, 38'h10_0000_0001);
        idle(0, 0, 0, 0, 0);
        chk("dir_pulse_end", valid_output, 1'b0);

        // Fill to full; 17th push dropped; push+pop on full holds full and wraps pointers.
        for (int i = 0; i < 17; i++) cycle(1, 2'd0, 38'(32'h100 + i), 0, 0, 0, 0, 0);
        chk("dir_full16", full, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1, 2'd0, 38'(32'h200 + i), 1, 1, 32'h100 + 32'(i % 8), 0, 0);
        chk("dir_full_pushpop", full, 1'b1);
        idle(0, 0, 0, 1, 4'd3);
        chk("dir_fetch3", fetch_data, dt[3]);
        idle(0, 0, 0, 0, 4'd3);
        chk("dir_fetch_off", fetch_data, 128'h0);
        for (int i = 0; i < 18; i++) idle(1, 0, 0, 0, 0);

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 500; c++) begin
                r = $urandom_range(0, 99);
                o = (r < 45) ? 2'd0 : (r < 80) ? 2'd1 : 2'($urandom_range(2, 3));
                bi[37:32] = 6'($urandom);
                bi[31:0]  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
                cycle($urandom_range(0, 3) != 0, o, bi,
                      (p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 1) == 1, 32'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1, 4'($urandom));
            end
        end

        // Drain: finish any pending write data, then pop everything.
        for (int i = 0; i < 8; i++) cycle(1, 2'd2, 38'($urandom), 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) idle(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("drain_pending_pops", exp_q.size(), 0);
        chk("drain_empty", empty, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
